// File: rtl/reset_seq_pkg.sv
// rtl/reset_seq_pkg.sv - shared state encoding and defaults for the reset sequencer
package reset_seq_pkg;

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    RELEASE = 2'd1,
    RUN     = 2'd2
  } seq_state_e;

  localparam int DEF_NUM_STAGES  = 4;
  localparam int DEF_HOLD_CYCLES = 16;
  localparam int DEF_STAGE_DELAY = 8;
  localparam int CNT_W           = 4;

  // Counts only reach max-1, so clog2(max) bits never wrap; never narrower than 1 bit.
  function automatic int timer_width(input int hold_cycles, input int stage_delay);
    int m;
    m = (hold_cycles > stage_delay) ? hold_cycles : stage_delay;
    return (m <= 1) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/seq_timer.sv
// rtl/seq_timer.sv - clearable up-counter with terminal-count compare
module seq_timer
  import reset_seq_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             sync_reset_n_i,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] tc_val_i,
  output logic             tc_o
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk) begin
    if (!sync_reset_n_i || clr_i) begin
      count_q <= '0;
    end else if (en_i) begin
      count_q <= count_q + WIDTH'(1);
    end
  end

  assign tc_o = (count_q == tc_val_i);

endmodule

// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - staged release of per-domain resets after hold, with soft re-run
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int NUM_STAGES  = DEF_NUM_STAGES,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter int STAGE_DELAY = DEF_STAGE_DELAY
) (
  input  logic                  clk,
  input  logic                  sync_reset_n,
  input  logic                  soft_reset_req,
  output logic [NUM_STAGES-1:0] async_reset,
  output logic                  soft_reset_ack,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_W-1:0]      released_cnt
);

  localparam int               TW       = timer_width(HOLD_CYCLES, STAGE_DELAY);
  localparam logic [TW-1:0]    HOLD_TC  = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0]    STAGE_TC = TW'(STAGE_DELAY - 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_STAGES - 1);

  seq_state_e            state_q;
  logic [NUM_STAGES-1:0] rst_q, rst_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  busy_q, done_q, ack_q;
  logic                  tc, tmr_clr, tmr_en;
  logic [TW-1:0]         tc_val;

  always_comb begin
    // Domains release bottom-up, so a left shift clears exactly the next bit.
    rst_d   = rst_q << 1;
    cnt_d   = cnt_q + CNT_W'(1);
    tc_val  = (state_q == HOLD) ? HOLD_TC : STAGE_TC;
    tmr_en  = (state_q != RUN);
    tmr_clr = soft_reset_req || (state_q == RUN) || tc;
  end

  seq_timer #(.WIDTH(TW)) u_timer (
    .clk            (clk),
    .sync_reset_n_i (sync_reset_n),
    .clr_i          (tmr_clr),
    .en_i           (tmr_en),
    .tc_val_i       (tc_val),
    .tc_o           (tc)
  );

  always_ff @(posedge clk) begin
    if (!sync_reset_n || soft_reset_req) begin
      state_q <= HOLD;
      rst_q   <= '1;
      cnt_q   <= '0;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
      ack_q   <= sync_reset_n;
    end else begin
      ack_q <= 1'b0;
      case (state_q)
        HOLD: begin
          if (tc) begin
            rst_q <= rst_d;
            cnt_q <= cnt_d;
            if (NUM_STAGES == 1) begin
              state_q <= RUN;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= RELEASE;
            end
          end
        end
        RELEASE: begin
          if (tc) begin
            rst_q <= rst_d;
            cnt_q <= cnt_d;
            if (cnt_q == LAST_IDX) begin
              state_q <= RUN;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        RUN: begin
        end
        default: begin
          state_q <= HOLD;
          rst_q   <= '1;
          cnt_q   <= '0;
          busy_q  <= 1'b1;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign async_reset    = rst_q;
  assign released_cnt   = cnt_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign soft_reset_ack = ack_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// tb/tb_reset_sequencer.sv - scoreboard bench for default and single-stage sequencers
module tb_reset_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rn0, soft0, ack0, busy0, done0;
  logic [3:0] ar0, cnt0;
  logic       rn1, soft1, ack1, busy1, done1;
  logic [0:0] ar1;
  logic [3:0] cnt1;

  reset_sequencer u_dut0 (
    .clk(clk), .sync_reset_n(rn0), .soft_reset_req(soft0), .async_reset(ar0),
    .soft_reset_ack(ack0), .busy(busy0), .done(done0), .released_cnt(cnt0)
  );

  reset_sequencer #(.NUM_STAGES(1), .HOLD_CYCLES(1), .STAGE_DELAY(1)) u_dut1 (
    .clk(clk), .sync_reset_n(rn1), .soft_reset_req(soft1), .async_reset(ar1),
    .soft_reset_ack(ack1), .busy(busy1), .done(done1), .released_cnt(cnt1)
  );

  typedef struct {
    int         cyc;
    logic [3:0] rst;
    logic [3:0] cnt;
    logic       busy;
    logic       done;
    logic       ack;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   ackq0[$];
  int   ackq1[$];
  exp_t me0, me1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  logic [3:0] prev0, therm0;
  logic [0:0] prev1, therm1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, req);
    end
  endtask

  task automatic exp0(input int c, input logic [3:0] r, input logic [3:0] n,
                      input logic b, input logic d, input logic a);
    exp_t e;
    e = '{c, r, n, b, d, a};
    q0.push_back(e);
  endtask

  task automatic exp1(input int c, input logic [3:0] r, input logic [3:0] n,
                      input logic b, input logic d, input logic a);
    exp_t e;
    e = '{c, r, n, b, d, a};
    q1.push_back(e);
  endtask

  task automatic goto(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  always @(negedge clk) begin
    while (q0.size() > 0 && q0[0].cyc <= cyc) begin
      me0 = q0.pop_front();
      check("rst0", ar0, me0.rst);
      check("cnt0", cnt0, me0.cnt);
      check("busy0", busy0, me0.busy);
      check("done0", done0, me0.done);
      check("ack0", ack0, me0.ack);
    end
    while (q1.size() > 0 && q1[0].cyc <= cyc) begin
      me1 = q1.pop_front();
      check("rst1", ar1, me1.rst[0:0]);
      check("cnt1", cnt1, me1.cnt);
      check("busy1", busy1, me1.busy);
      check("done1", done1, me1.done);
      check("ack1", ack1, me1.ack);
    end
    if (ack0 === 1'b1) begin
      if (ackq0.size() == 0) check("ack0_unexpected", 1, 0);
      else check("ack0_cycle", cyc, ackq0.pop_front());
    end
    if (ack1 === 1'b1) begin
      if (ackq1.size() == 0) check("ack1_unexpected", 1, 0);
      else check("ack1_cycle", cyc, ackq1.pop_front());
    end
    if (cyc >= 1) begin
      therm0 = 4'b1111 << cnt0;
      therm1 = (cnt1 == 4'd0) ? 1'b1 : 1'b0;
      check("therm0", ar0, therm0);
      check("therm1", ar1, therm1);
      if ((~prev0 & ar0) != 4'd0) check("rerise0", {busy0, cnt0}, 5'b10000);
      if ((~prev1 & ar1) != 1'b0) check("rerise1", {busy1, cnt1}, 5'b10000);
    end
    prev0 = ar0;
    prev1 = ar1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rn1 = 1'b0; soft1 = 1'b0;
    exp1(2, 4'h1, 4'd0, 1'b1, 1'b0, 1'b0);
    goto(2);
    rn1 = 1'b1;
    exp1(3, 4'h0, 4'd1, 1'b0, 1'b1, 1'b0);
    exp1(4, 4'h0, 4'd1, 1'b0, 1'b1, 1'b0);
    goto(10);
    exp1(11, 4'h1, 4'd0, 1'b1, 1'b0, 1'b1);
    ackq1.push_back(11);
    exp1(12, 4'h0, 4'd1, 1'b0, 1'b1, 1'b0);
    soft1 = 1'b1;
    goto(11);
    soft1 = 1'b0;
  end

  initial begin
    int b, e, f, g, h, k, m;
    rn0 = 1'b0; soft0 = 1'b0;
    // Power-on: three edges in reset, then edge b+1 is the first released edge.
    exp0(1, 4'hF, 4'd0, 1'b1, 1'b0, 1'b0);
    exp0(3, 4'hF, 4'd0, 1'b1, 1'b0, 1'b0);
    b = 3;
    exp0(b + 15, 4'hF, 4'd0, 1'b1, 1'b0, 1'b0);
    exp0(b + 16, 4'hE, 4'd1, 1'b1, 1'b0, 1'b0);
    exp0(b + 23, 4'hE, 4'd1, 1'b1, 1'b0, 1'b0);
    exp0(b + 24, 4'hC, 4'd2, 1'b1, 1'b0, 1'b0);
    exp0(b + 32, 4'h8, 4'd3, 1'b1, 1'b0, 1'b0);
    exp0(b + 39, 4'h8, 4'd3, 1'b1, 1'b0, 1'b0);
    exp0(b + 40, 4'h0, 4'd4, 1'b0, 1'b1, 1'b0);
    exp0(b + 41, 4'h0, 4'd4, 1'b0, 1'b1, 1'b0);
    goto(b);
    rn0 = 1'b1;
    goto(b + 41);

    // One-cycle soft request from RUN.
    e = cyc + 1;
    exp0(e, 4'hF, 4'd0, 1'b1, 1'b0, 1'b1);
    ackq0.push_back(e);
    exp0(e + 1, 4'hF, 4'd0, 1'b1, 1'b0, 1'b0);
    exp0(e + 16, 4'hE, 4'd1, 1'b1, 1'b0, 1'b0);
    exp0(e + 39, 4'h8, 4'd3, 1'b1, 1'b0, 1'b0);
    exp0(e + 40, 4'h0, 4'd4, 1'b0, 1'b1, 1'b0);
    soft0 = 1'b1;
    goto(e);
    soft0 = 1'b0;
    goto(e + 41);

    // Soft request again while two domains are released.
    f = cyc + 1;
    g = f + 28;
    exp0(f, 4'hF, 4'd0, 1'b1, 1'b0, 1'b1);
    ackq0.push_back(f);
    exp0(f + 24, 4'hC, 4'd2, 1'b1, 1'b0, 1'b0);
    exp0(g - 1, 4'hC, 4'd2, 1'b1, 1'b0, 1'b0);
    exp0(g, 4'hF, 4'd0, 1'b1, 1'b0, 1'b1);
    ackq0.push_back(g);
    exp0(g + 1, 4'hF, 4'd0, 1'b1, 1'b0, 1'b0);
    exp0(g + 16, 4'hE, 4'd1, 1'b1, 1'b0, 1'b0);
    exp0(g + 32, 4'h8, 4'd3, 1'b1, 1'b0, 1'b0);
    soft0 = 1'b1;
    goto(f);
    soft0 = 1'b0;
    goto(g - 1);
    soft0 = 1'b1;
    goto(g);
    soft0 = 1'b0;

    // One-cycle hard reset at three released, with a simultaneous soft request.
    h = g + 34;
    exp0(h - 1, 4'h8, 4'd3, 1'b1, 1'b0, 1'b0);
    exp0(h, 4'hF, 4'd0, 1'b1, 1'b0, 1'b0);
    exp0(h + 16, 4'hE, 4'd1, 1'b1, 1'b0, 1'b0);
    exp0(h + 40, 4'h0, 4'd4, 1'b0, 1'b1, 1'b0);
    goto(h - 1);
    rn0 = 1'b0;
    soft0 = 1'b1;
    goto(h);
    rn0 = 1'b1;
    soft0 = 1'b0;
    goto(h + 41);

    // Held soft request, then a request landing on the final-release edge.
    k = cyc + 1;
    m = k + 2;
    exp0(k, 4'hF, 4'd0, 1'b1, 1'b0, 1'b1);
    exp0(k + 1, 4'hF, 4'd0, 1'b1, 1'b0, 1'b1);
    exp0(m, 4'hF, 4'd0, 1'b1, 1'b0, 1'b1);
    ackq0.push_back(k);
    ackq0.push_back(k + 1);
    ackq0.push_back(m);
    exp0(m + 15, 4'hF, 4'd0, 1'b1, 1'b0, 1'b0);
    exp0(m + 16, 4'hE, 4'd1, 1'b1, 1'b0, 1'b0);
    exp0(m + 39, 4'h8, 4'd3, 1'b1, 1'b0, 1'b0);
    exp0(m + 40, 4'hF, 4'd0, 1'b1, 1'b0, 1'b1);
    ackq0.push_back(m + 40);
    exp0(m + 41, 4'hF, 4'd0, 1'b1, 1'b0, 1'b0);
    exp0(m + 56, 4'hE, 4'd1, 1'b1, 1'b0, 1'b0);
    soft0 = 1'b1;
    goto(m);
    soft0 = 1'b0;
    goto(m + 39);
    soft0 = 1'b1;
    goto(m + 40);
    soft0 = 1'b0;
    goto(m + 58);

    check("q0_drained", q0.size(), 0);
    check("q1_drained", q1.size(), 0);
    check("ackq0_drained", ackq0.size(), 0);
    check("ackq1_drained", ackq1.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 SHALL have parameter NUM_STAGES, default 4, number of reset domains (legal 1..8).
REQ-002 SHALL have parameter HOLD_CYCLES, default 16, cycles all domains stay in reset before the first release (legal >=1).
REQ-003 SHALL have parameter STAGE_DELAY, default 8, cycles between consecutive domain releases (legal >=1).
REQ-004 SHALL have port: clk  input  1  clock; one clock only, all state on its rising edge.
REQ-005 SHALL have port: sync_reset_n  input  1  reset; synchronous, active-low.
REQ-006 SHALL have port: soft_reset_req  input  1  level/pulse request to re-run the sequence.
REQ-007 SHALL have port: async_reset  output  NUM_STAGES  active-high reset per downstream flip-flop domain; bit i = stage i.
REQ-008 SHALL have port: soft_reset_ack  output  1  one-cycle pulse, soft request accepted.
REQ-009 SHALL have port: busy  output  1  sequence in progress (HOLD or RELEASE).
REQ-010 SHALL have port: done  output  1  all domains released, state RUN.
REQ-011 SHALL have port: released_cnt  output  4  number of domains currently released (0..NUM_STAGES).

Function
REQ-012 SHALL implement states HOLD, RELEASE, RUN, with one timer counter and one stage index.
REQ-013 HOLD: all async_reset bits 1; timer increments each cycle; at the edge where timer == HOLD_CYCLES-1, SHALL clear async_reset[0], set released_cnt=1, clear the timer, and go to RELEASE (go to RUN if NUM_STAGES==1).
REQ-014 RELEASE: at the edge where timer == STAGE_DELAY-1, SHALL clear async_reset[released_cnt], increment released_cnt, and clear the timer; when the last bit clears, SHALL go to RUN.
REQ-015 Release order SHALL be strictly bit 0 upward; a released bit SHALL stay 0 until the next HOLD entry.
REQ-016 RUN: async_reset all 0, done=1, busy=0; timer held at 0.
REQ-017 soft_reset_req=1 sampled in any state SHALL, at that edge, set all async_reset bits to 1, clear the timer and released_cnt, enter HOLD, and pulse soft_reset_ack for exactly that following cycle.
REQ-018 soft_reset_req held high SHALL keep the block in HOLD with timer 0 and SHALL re-pulse soft_reset_ack every cycle; release timing starts from the first edge with the request low.
REQ-019 soft_reset_req coinciding with the final-release edge SHALL win: no RUN entry, done stays 0.
REQ-020 busy = (state != RUN); done = (state == RUN); both registered.
REQ-021 async_reset bits SHALL be driven directly from flip-flops, with no combinational decode, so downstream async resets see glitch-free edges.
REQ-022 Timer width SHALL be clog2(max(HOLD_CYCLES, STAGE_DELAY)), minimum 1 bit; no wrap-around SHALL occur in legal configurations.
REQ-023 Default timing after reset release (edge 1 = first edge with sync_reset_n=1): bit0 falls after edge 16, bit1 after 24, bit2 after 32, bit3 after 40; done=1 after edge 40.

Reset
REQ-024 sync_reset_n=0 sampled at an edge SHALL set state=HOLD, timer=0, released_cnt=0, async_reset=all 1, busy=1, done=0, soft_reset_ack=0; it has priority over soft_reset_req.
REQ-025 Reset asserted mid-sequence or in RUN SHALL re-assert every domain at that edge, with no partial-release state kept.

Structure
REQ-026 A shared package reset_seq_pkg SHALL hold the state enum (HOLD, RELEASE, RUN) and the default parameter constants.
REQ-027 The timer SHALL be a sub-module seq_timer (clear, enable, terminal-count compare output, parameterised width).

Verification
REQ-028 Power-on: sync_reset_n low 3 cycles then high, defaults -> async_reset 4'b1111 through edge 16, 4'b1110 after 16, 4'b1100 after 24, 4'b1000 after 32, 4'b0000 and done=1 after 40.
REQ-029 Soft reset in RUN: one-cycle soft_reset_req -> next cycle async_reset=4'b1111, soft_reset_ack=1 for one cycle, busy=1; full release 40 cycles after the request edge.
REQ-030 Soft reset during RELEASE (released_cnt=2) -> all bits return to 1 and released_cnt=0; sequence restarts from HOLD.
REQ-031 sync_reset_n pulsed low for 1 cycle at released_cnt=3 -> async_reset=4'b1111 next cycle; soft_reset_req=1 on the same edge produces no ack.
REQ-032 soft_reset_req on the final-release edge -> done never asserts; async_reset=4'b1111.
REQ-033 NUM_STAGES=1, HOLD_CYCLES=1, STAGE_DELAY=1 -> async_reset falls and done rises after edge 1; the assertion checker never sees a released bit re-rise outside HOLD.
